// File: rtl/allophone_feeder_if.sv
// Host-write and core-load handshake bundle for allophone_feeder.
interface allophone_feeder_if #(
   parameter int ADDR_W = 4
);
   logic              wr_en;
   logic [5:0]        wr_data;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   level;
   logic              ldq;
   logic [5:0]        data_out;
   logic              data_stb;
   logic              busy;
   logic              overflow;
   logic              timeout_err;
   logic              clr_err;

   modport master (
      output wr_en, wr_data, ldq, clr_err,
      input  full, empty, level, data_out, data_stb,
      input  busy, overflow, timeout_err
   );

   modport slave (
      input  wr_en, wr_data, ldq, clr_err,
      output full, empty, level, data_out, data_stb,
      output busy, overflow, timeout_err
   );
endinterface

// File: rtl/allophone_feeder.sv
// Allophone FIFO feeding a speech core via the ldq/data_stb load handshake.
// ALLOPHONE_FEEDER_AUTOPAUSE_EN adds a trailing PAUSE_CODE after each utterance.
module allophone_feeder #(
   parameter int         DEPTH       = 16,
   parameter int         ADDR_W      = 4,
   parameter int         ACK_TIMEOUT = 1024,
   parameter logic [5:0] PAUSE_CODE  = 6'd4
) (
   input logic               clk,
   input logic               rst,
   allophone_feeder_if.slave bus
);
   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_LOW,
      S_WAIT_HIGH
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [5:0]        r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_level;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [5:0]        r_data_out;
   logic              r_data_stb;
   logic              r_overflow;
   logic              r_timeout_err;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic              w_pause;
   logic              w_pause_ok;
   logic              w_stb;
   logic              w_to_set;
   logic [5:0]        w_stb_code;

   assign w_full     = (r_level == (ADDR_W+1)'(DEPTH));
   assign w_empty    = (r_level == '0);
   assign w_push     = bus.wr_en && !w_full;
   assign w_stb      = w_pop || w_pause;
   assign w_stb_code = w_pause ? PAUSE_CODE : r_mem[r_rd_ptr];

`ifdef ALLOPHONE_FEEDER_AUTOPAUSE_EN
   logic r_need_pause;

   // Armed by any real code, disarmed once the pause itself goes out
   always_ff @(posedge clk) begin
      if (rst) begin
         r_need_pause <= 1'b0;
      end else if (w_stb) begin
         r_need_pause <= (w_stb_code != PAUSE_CODE);
      end
   end

   assign w_pause_ok = r_need_pause;
`else
   assign w_pause_ok = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pop       = 1'b0;
      w_pause     = 1'b0;
      w_to_set    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.ldq && !w_empty) begin
               w_pop       = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = S_WAIT_LOW;
            end else if (bus.ldq && w_pause_ok) begin
               w_pause     = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = S_WAIT_LOW;
            end
         end
         S_WAIT_LOW: begin
            if (!bus.ldq) begin
               w_state_nxt = S_WAIT_HIGH;
            end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
               w_to_set    = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_WAIT_HIGH: begin
            if (bus.ldq) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_level       <= '0;
         r_data_out    <= '0;
         r_data_stb    <= 1'b0;
         r_overflow    <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
         r_data_stb <= w_stb;
         if (w_stb) r_data_out <= w_stb_code;
         // Set beats clear when both land on the same edge
         if (bus.wr_en && w_full) r_overflow <= 1'b1;
         else if (bus.clr_err)    r_overflow <= 1'b0;
         if (w_to_set)            r_timeout_err <= 1'b1;
         else if (bus.clr_err)    r_timeout_err <= 1'b0;
      end
   end

   assign bus.full        = w_full;
   assign bus.empty       = w_empty;
   assign bus.level       = r_level;
   assign bus.data_out    = r_data_out;
   assign bus.data_stb    = r_data_stb;
   assign bus.busy        = (r_state != S_IDLE) || !w_empty;
   assign bus.overflow    = r_overflow;
   assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_allophone_feeder.sv
// Directed bench for allophone_feeder with a strobe scoreboard and core model.
module tb_allophone_feeder;
   localparam int ACK = 1024;

   logic clk = 1'b0;
   logic rst = 1'b1;

   allophone_feeder_if #(.ADDR_W(4)) bus ();

   allophone_feeder #(
      .DEPTH(16),
      .ADDR_W(4),
      .ACK_TIMEOUT(ACK),
      .PAUSE_CODE(6'd4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         nstb   = 0;
   int         hold   = 0;
   bit         auto_core = 1'b0;
   bit         prev_stb  = 1'b0;
   logic [5:0] q [$];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic [5:0] e;
      @(posedge clk);
      #1;
      if (bus.data_stb) begin
         nstb++;
         e = (q.size() > 0) ? q.pop_front() : 6'bx;
         chk("stb_code", {26'd0, bus.data_out}, {26'd0, e});
         chk("stb_pulse", {31'd0, prev_stb}, 32'd0);
         hold = 50;
      end
      prev_stb = bus.data_stb;
      if (auto_core) begin
         if (hold > 0) begin
            bus.ldq = 1'b0;
            hold--;
         end else begin
            bus.ldq = 1'b1;
         end
      end
   endtask

   task automatic wr(input logic [5:0] c);
      bus.wr_en   = 1'b1;
      bus.wr_data = c;
      tick();
      bus.wr_en   = 1'b0;
   endtask

   initial begin
      int n;
      int s0;
      bus.wr_en   = 1'b0;
      bus.wr_data = '0;
      bus.ldq     = 1'b1;
      bus.clr_err = 1'b0;

      // reset state with ldq high and nothing queued
      tick();
      tick();
      chk("rst_level", 32'(bus.level), 32'd0);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_full", 32'(bus.full), 32'd0);
      chk("rst_dout", 32'(bus.data_out), 32'd0);
      chk("rst_stb", 32'(bus.data_stb), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_ovf", 32'(bus.overflow), 32'd0);
      chk("rst_to", 32'(bus.timeout_err), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 100; i++) tick();
      chk("idle_nstb", 32'(nstb), 32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_dout", 32'(bus.data_out), 32'd0);

      // three codes through the handshaking core model
      auto_core = 1'b1;
      s0 = nstb;
      for (int i = 6; i <= 8; i++) begin
         q.push_back(6'(i));
         wr(6'(i));
      end
`ifdef ALLOPHONE_FEEDER_AUTOPAUSE_EN
      q.push_back(6'd4);
`endif
      for (int i = 0; i < 400; i++) tick();
      chk("seq_qleft", 32'(q.size()), 32'd0);
`ifdef ALLOPHONE_FEEDER_AUTOPAUSE_EN
      chk("seq_nstb", 32'(nstb - s0), 32'd4);
`else
      chk("seq_nstb", 32'(nstb - s0), 32'd3);
`endif
      chk("seq_level", 32'(bus.level), 32'd0);
      chk("seq_busy", 32'(bus.busy), 32'd0);

      // overflow: 17 writes with the core stalled
      auto_core = 1'b0;
      bus.ldq   = 1'b0;
      tick();
      for (int i = 0; i < 17; i++) begin
         if (i < 16) q.push_back(6'(10 + i));
         wr(6'(10 + i));
      end
      chk("ovf_level", 32'(bus.level), 32'd16);
      chk("ovf_full", 32'(bus.full), 32'd1);
      chk("ovf_flag", 32'(bus.overflow), 32'd1);
      chk("ovf_busy", 32'(bus.busy), 32'd1);
      bus.clr_err = 1'b1;
      wr(6'd40);
      chk("ovf_setwins", 32'(bus.overflow), 32'd1);
      chk("ovf_level2", 32'(bus.level), 32'd16);
      tick();
      bus.clr_err = 1'b0;
      chk("ovf_clr", 32'(bus.overflow), 32'd0);

      // timeout with ldq stuck high
      s0 = nstb;
      bus.ldq = 1'b1;
      tick();
      chk("to_stb0", 32'(bus.data_stb), 32'd1);
      n = 0;
      while (!bus.timeout_err && n < 2000) begin
         tick();
         n++;
      end
      chk("to_cycles", 32'(n), 32'(ACK));
      chk("to_flag", 32'(bus.timeout_err), 32'd1);
      tick();
      chk("to_stb1", 32'(bus.data_stb), 32'd1);
      chk("to_nstb", 32'(nstb - s0), 32'd2);
      bus.ldq = 1'b0;
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      chk("to_clr", 32'(bus.timeout_err), 32'd0);
      chk("to_level", 32'(bus.level), 32'd14);

      // reset while parked in WAIT_HIGH with five codes queued
      rst = 1'b1;
      tick();
      rst = 1'b0;
      q.delete();
      for (int i = 30; i < 36; i++) begin
         q.push_back(6'(i));
         wr(6'(i));
      end
      bus.ldq = 1'b1;
      tick();
      chk("mid_stb", 32'(bus.data_stb), 32'd1);
      bus.ldq = 1'b0;
      tick();
      chk("mid_level", 32'(bus.level), 32'd5);
      chk("mid_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      q.delete();
      chk("mid_rlevel", 32'(bus.level), 32'd0);
      chk("mid_rempty", 32'(bus.empty), 32'd1);
      chk("mid_rstb", 32'(bus.data_stb), 32'd0);
      chk("mid_rbusy", 32'(bus.busy), 32'd0);
      s0 = nstb;
      bus.ldq = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      chk("mid_nostb", 32'(nstb - s0), 32'd0);

      // single code, optionally followed by the auto-pause
      auto_core = 1'b1;
      s0 = nstb;
      q.push_back(6'd9);
`ifdef ALLOPHONE_FEEDER_AUTOPAUSE_EN
      q.push_back(6'd4);
`endif
      wr(6'd9);
      for (int i = 0; i < 300; i++) tick();
      chk("ap_qleft", 32'(q.size()), 32'd0);
`ifdef ALLOPHONE_FEEDER_AUTOPAUSE_EN
      chk("ap_nstb", 32'(nstb - s0), 32'd2);
`else
      chk("ap_nstb", 32'(nstb - s0), 32'd1);
`endif
      chk("ap_busy", 32'(bus.busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
